// File: rtl/kyber_bram_pkg.sv
// Shared constants and types for the Kyber coefficient BRAM (64 x 12-bit words).
package kyber_bram_pkg;
  localparam int ADDR_W     = 6;
  localparam int DATA_W     = 12;
  localparam int BRAM_DEPTH = 64;
  localparam int Q          = 3329;

  typedef logic [ADDR_W-1:0] bram_addr_t;
  typedef logic [DATA_W-1:0] bram_data_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant from the first valid index at or after ptr.
// ptr moves to winner+1 when advance is high and holds otherwise. Grant is forced to zero while reset is high.
module rr_arbiter #(
  parameter int N = 4,
  localparam int PW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  valid,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] ptr
);
  logic [PW:0]   idx;
  logic [PW-1:0] win;
  logic [PW-1:0] nxt;
  logic          found;

  always_comb begin
    grant = '0;
    win   = '0;
    idx   = '0;
    found = 1'b0;
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        // Scan from ptr with a wrap, so ptr itself has the highest priority.
        idx = {1'b0, ptr} + (PW+1)'(i);
        if (idx >= (PW+1)'(N)) idx = idx - (PW+1)'(N);
        if (!found && valid[idx[PW-1:0]]) begin
          found                 = 1'b1;
          grant[idx[PW-1:0]]    = 1'b1;
          win                   = idx[PW-1:0];
        end
      end
    end
  end

  assign nxt = (win == PW'(N-1)) ? '0 : win + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        ptr <= '0;
    else if (advance) ptr <= nxt;
  end
endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one simple-dual-port BRAM among NREQ requesters with independent round-robin read and write grants; responses return 1 cc after the read grant.
// Defining BRAM_ARB_BYPASS_EN forwards same-cycle same-address write data to the read response.
module bram_port_arbiter #(
  parameter int NREQ   = 4,
  parameter int ADDR_W = kyber_bram_pkg::ADDR_W,
  parameter int DATA_W = kyber_bram_pkg::DATA_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        rd_valid,
  input  logic [NREQ*ADDR_W-1:0] rd_addr,
  output logic [NREQ-1:0]        rd_ready,
  input  logic [NREQ-1:0]        wr_valid,
  input  logic [NREQ*ADDR_W-1:0] wr_addr,
  input  logic [NREQ*DATA_W-1:0] wr_data,
  output logic [NREQ-1:0]        wr_ready,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]      rsp_data,
  output logic                   bram_wen,
  output logic [ADDR_W-1:0]      bram_waddr,
  output logic [DATA_W-1:0]      bram_din,
  output logic [ADDR_W-1:0]      bram_raddr,
  input  logic [DATA_W-1:0]      bram_dout
);
  import kyber_bram_pkg::*;

  localparam int PW = $clog2(NREQ);

  logic [NREQ-1:0] rd_grant;
  logic [NREQ-1:0] wr_grant;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;

  rr_arbiter #(.N(NREQ)) u_rd_arb (
    .clk     (clk),
    .reset   (reset),
    .valid   (rd_valid),
    .advance (|rd_grant),
    .grant   (rd_grant),
    .ptr     (rd_ptr)
  );

  rr_arbiter #(.N(NREQ)) u_wr_arb (
    .clk     (clk),
    .reset   (reset),
    .valid   (wr_valid),
    .advance (|wr_grant),
    .grant   (wr_grant),
    .ptr     (wr_ptr)
  );

  assign rd_ready = rd_grant;
  assign wr_ready = wr_grant;
  assign bram_wen = (|wr_grant) & ~reset;

  // Grants are one-hot or zero, so an AND-OR mux yields zero when nobody wins.
  always_comb begin
    bram_waddr = '0;
    bram_din   = '0;
    bram_raddr = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (wr_grant[i]) begin
        bram_waddr = bram_waddr | wr_addr[i*ADDR_W +: ADDR_W];
        bram_din   = bram_din   | wr_data[i*DATA_W +: DATA_W];
      end
      if (rd_grant[i]) bram_raddr = bram_raddr | rd_addr[i*ADDR_W +: ADDR_W];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rsp_valid <= '0;
    else       rsp_valid <= rd_grant;
  end

`ifdef BRAM_ARB_BYPASS_EN
  logic              hit_q;
  logic [DATA_W-1:0] fwd_q;

  // The BRAM returns old data on a same-address collision; remember the new word instead.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_q <= 1'b0;
      fwd_q <= '0;
    end else begin
      hit_q <= (|wr_grant) & (|rd_grant) & (bram_waddr == bram_raddr);
      fwd_q <= bram_din;
    end
  end

  assign rsp_data = hit_q ? fwd_q : bram_dout;
`else
  assign rsp_data = bram_dout;
`endif

  a_ptr_range: assert property (@(posedge clk) disable iff (reset)
    (int'(rd_ptr) < NREQ) && (int'(wr_ptr) < NREQ));
  a_onehot: assert property (@(posedge clk) disable iff (reset)
    $onehot0(rd_grant) && $onehot0(wr_grant));
endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: directed scenarios plus randomized held requests, checked against a
// behavioural model (round-robin priority lists, expected memory image, expected responses).
module tb_bram_port_arbiter;
  localparam int NREQ = 4;
  localparam int AW   = 6;
  localparam int DW   = 12;
`ifdef BRAM_ARB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic               clk;
  logic               reset;
  logic [NREQ-1:0]    rd_valid;
  logic [NREQ*AW-1:0] rd_addr;
  logic [NREQ-1:0]    rd_ready;
  logic [NREQ-1:0]    wr_valid;
  logic [NREQ*AW-1:0] wr_addr;
  logic [NREQ*DW-1:0] wr_data;
  logic [NREQ-1:0]    wr_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_data;
  logic               bram_wen;
  logic [AW-1:0]      bram_waddr;
  logic [DW-1:0]      bram_din;
  logic [AW-1:0]      bram_raddr;
  logic [DW-1:0]      bram_dout;

  bram_port_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .bram_wen(bram_wen), .bram_waddr(bram_waddr), .bram_din(bram_din),
    .bram_raddr(bram_raddr), .bram_dout(bram_dout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // BRAM behavioural model: 1 cc registered read, read-before-write.
  logic [DW-1:0] bmem [64];
  always @(posedge clk) begin
    if (bram_wen) bmem[bram_waddr] <= bram_din;
    bram_dout <= bmem[bram_raddr];
  end

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state
  int            rp, wp;
  logic [DW-1:0] exp_mem [64];
  logic [3:0]    exp_rv;
  logic [DW-1:0] exp_rd;
  int            last_rd, last_wr;

  function automatic int pick(logic [3:0] v, int p);
    int idx;
    for (int k = 0; k < NREQ; k++) begin
      idx = (p + k) % NREQ;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  // Called at a negedge with inputs already driven; checks this cycle, advances the model, returns at next negedge.
  task automatic step();
    int er, ew;
    logic [3:0] er_oh, ew_oh;
    logic [AW-1:0] era, ewa;
    logic [DW-1:0] ewd;
    #1;
    er = reset ? -1 : pick(rd_valid, rp);
    ew = reset ? -1 : pick(wr_valid, wp);
    er_oh = (er >= 0) ? 4'(1 << er) : 4'b0;
    ew_oh = (ew >= 0) ? 4'(1 << ew) : 4'b0;
    era = (er >= 0) ? rd_addr[er*AW +: AW] : '0;
    ewa = (ew >= 0) ? wr_addr[ew*AW +: AW] : '0;
    ewd = (ew >= 0) ? wr_data[ew*DW +: DW] : '0;
    if (reset) exp_rv = 4'b0;

    n_chk++; if (rd_ready !== er_oh) begin n_fail++; $display("FAIL rd_ready got %b want %b t=%0t", rd_ready, er_oh, $time); end
    n_chk++; if (wr_ready !== ew_oh) begin n_fail++; $display("FAIL wr_ready got %b want %b t=%0t", wr_ready, ew_oh, $time); end
    n_chk++; if (bram_wen !== (ew >= 0)) begin n_fail++; $display("FAIL bram_wen got %b want %b t=%0t", bram_wen, (ew >= 0), $time); end
    n_chk++; if (bram_raddr !== era) begin n_fail++; $display("FAIL bram_raddr got %0d want %0d t=%0t", bram_raddr, era, $time); end
    n_chk++; if (bram_waddr !== ewa) begin n_fail++; $display("FAIL bram_waddr got %0d want %0d t=%0t", bram_waddr, ewa, $time); end
    n_chk++; if (bram_din !== ewd) begin n_fail++; $display("FAIL bram_din got %h want %h t=%0t", bram_din, ewd, $time); end
    n_chk++; if (rsp_valid !== exp_rv) begin n_fail++; $display("FAIL rsp_valid got %b want %b t=%0t", rsp_valid, exp_rv, $time); end
    if (exp_rv != 4'b0) begin
      n_chk++; if (rsp_data !== exp_rd) begin n_fail++; $display("FAIL rsp_data got %h want %h t=%0t", rsp_data, exp_rd, $time); end
    end

    exp_rv = er_oh;
    if (er >= 0) exp_rd = (BYP && ew >= 0 && ewa == era) ? ewd : exp_mem[era];
    if (ew >= 0) exp_mem[ewa] = ewd;
    if (reset) begin
      rp = 0; wp = 0;
    end else begin
      if (er >= 0) rp = (er + 1) % NREQ;
      if (ew >= 0) wp = (ew + 1) % NREQ;
    end
    last_rd = er;
    last_wr = ew;
    @(negedge clk);
  endtask

  task automatic idle();
    rd_valid = '0; wr_valid = '0;
    rd_addr = '0; wr_addr = '0; wr_data = '0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    rd_valid = 4'b1111; wr_valid = 4'b1010;
    wr_addr = {4{6'd3}}; wr_data = {4{12'h555}}; rd_addr = {4{6'd9}};
    step();
    step();
    idle();
    reset = 1'b0;
    step();
    n_chk++; if (rsp_valid !== 4'b0) begin n_fail++; $display("FAIL reset_idle_rsp got %b want 0000", rsp_valid); end
  endtask

  task automatic test_single();
    idle();
    wr_valid[2] = 1'b1; wr_addr[2*AW +: AW] = 6'd5; wr_data[2*DW +: DW] = 12'hABC;
    step();
    idle();
    rd_valid[2] = 1'b1; rd_addr[2*AW +: AW] = 6'd5;
    #1;
    n_chk++; if (bram_wen !== 1'b0) begin n_fail++; $display("FAIL single_wen_pulse got %b want 0", bram_wen); end
    step();
    idle();
    n_chk++; if (rsp_valid !== 4'b0100 || rsp_data !== 12'hABC) begin
      n_fail++; $display("FAIL single_rsp got %b/%h want 0100/abc", rsp_valid, rsp_data);
    end
    step();
  endtask

  task automatic test_round_robin();
    int prev;
    idle();
    rd_valid = 4'b1111;
    for (int i = 0; i < NREQ; i++) rd_addr[i*AW +: AW] = AW'(20 + 3*i);
    prev = -1;
    for (int c = 0; c < 3*NREQ; c++) begin
      step();
      if (prev >= 0) begin
        n_chk++; if (last_rd != (prev + 1) % NREQ) begin n_fail++; $display("FAIL rr_order got %0d want %0d", last_rd, (prev + 1) % NREQ); end
      end
      prev = last_rd;
    end
    idle();
    step();
  endtask

  task automatic test_concurrent();
    idle();
    wr_valid[1] = 1'b1; wr_addr[1*AW +: AW] = 6'd9; wr_data[1*DW +: DW] = 12'h321;
    rd_valid[3] = 1'b1; rd_addr[3*AW +: AW] = 6'd10;
    #1;
    n_chk++; if (wr_ready !== 4'b0010 || rd_ready !== 4'b1000 || bram_wen !== 1'b1 || bram_raddr !== 6'd10) begin
      n_fail++; $display("FAIL concurrent got wr=%b rd=%b wen=%b raddr=%0d want 0010/1000/1/10", wr_ready, rd_ready, bram_wen, bram_raddr);
    end
    step();
    idle();
    step();
  endtask

  task automatic test_hazard();
    logic [DW-1:0] want;
    idle();
    wr_valid[0] = 1'b1; wr_addr[0*AW +: AW] = 6'd7; wr_data[0*DW +: DW] = 12'h001;
    step();
    idle();
    wr_valid[2] = 1'b1; wr_addr[2*AW +: AW] = 6'd7; wr_data[2*DW +: DW] = 12'h0D0;
    rd_valid[1] = 1'b1; rd_addr[1*AW +: AW] = 6'd7;
    step();
    idle();
    want = BYP ? 12'h0D0 : 12'h001;
    n_chk++; if (rsp_data !== want || rsp_valid !== 4'b0010) begin
      n_fail++; $display("FAIL hazard got %b/%h want 0010/%h", rsp_valid, rsp_data, want);
    end
    step();
  endtask

  task automatic test_reset_mid();
    idle();
    rd_valid[1] = 1'b1; rd_addr[1*AW +: AW] = 6'd20;
    wr_valid[3] = 1'b1; wr_addr[3*AW +: AW] = 6'd40; wr_data[3*DW +: DW] = 12'h777;
    step();
    idle();
    reset = 1'b1;
    step();
    n_chk++; if (rsp_valid !== 4'b0) begin n_fail++; $display("FAIL reset_drop got %b want 0000", rsp_valid); end
    reset = 1'b0;
    rd_valid = 4'b1111; wr_valid = 4'b1111;
    #1;
    n_chk++; if (rd_ready !== 4'b0001 || wr_ready !== 4'b0001) begin
      n_fail++; $display("FAIL reset_ptr got rd=%b wr=%b want 0001/0001", rd_ready, wr_ready);
    end
    step();
    idle();
    step();
  endtask

  task automatic test_random();
    int rwait [NREQ];
    int wwait [NREQ];
    int g;
    idle();
    for (int i = 0; i < NREQ; i++) begin rwait[i] = 0; wwait[i] = 0; end
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!rd_valid[i] && $urandom_range(1, 0) == 1) begin
          rd_valid[i] = 1'b1; rd_addr[i*AW +: AW] = AW'($urandom_range(15, 0)); rwait[i] = 0;
        end
        if (!wr_valid[i] && $urandom_range(1, 0) == 1) begin
          wr_valid[i] = 1'b1; wr_addr[i*AW +: AW] = AW'($urandom_range(15, 0));
          wr_data[i*DW +: DW] = DW'($urandom); wwait[i] = 0;
        end
      end
      step();
      for (int i = 0; i < NREQ; i++) begin
        if (rd_valid[i]) rwait[i]++;
        if (wr_valid[i]) wwait[i]++;
      end
      g = last_rd;
      if (g >= 0) begin
        n_chk++; if (rwait[g] > NREQ) begin n_fail++; $display("FAIL rd_starve req %0d waited %0d want <= %0d", g, rwait[g], NREQ); end
        rd_valid[g] = 1'b0;
      end
      g = last_wr;
      if (g >= 0) begin
        n_chk++; if (wwait[g] > NREQ) begin n_fail++; $display("FAIL wr_starve req %0d waited %0d want <= %0d", g, wwait[g], NREQ); end
        wr_valid[g] = 1'b0;
      end
    end
    idle();
    step();
    step();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin bmem[i] = '0; exp_mem[i] = '0; end
    rp = 0; wp = 0; exp_rv = '0; exp_rd = '0; last_rd = -1; last_wr = -1;
    reset = 1'b1;
    idle();
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_concurrent();
    test_hazard();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
